// File: rtl/mem_axi_bridge.sv
// mem_axi_bridge: turns the cache controller's req/rdy/valid memory port into AXI4
// master traffic -- single-beat INCR writes for write-through stores and INCR read
// bursts for line fills. One transaction is in flight at a time.
// Handshake rule used on every channel: a transfer happens on a rising clk edge where
// VALID and READY are both 1; a VALID, once raised, holds its payload until that edge.
// Upstream, a request is taken on an edge with i_req=1 and o_rdy=1, and each o_valid
// pulse carries exactly one read beat.
module mem_axi_bridge #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    localparam int BEN_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    // cache-side port
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_wen,
    input  logic [BEN_WIDTH-1:0]  i_ben,
    input  logic [7:0]            i_len,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_rdy,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_err,
    // AXI write address
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    // AXI write data
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [BEN_WIDTH-1:0]  m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    // AXI write response
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    // AXI read address
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    // AXI read data
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    // FSM state for checkers; 0 is IDLE
    output logic [2:0]            dbg_state
);

    localparam int SIZE = $clog2(BEN_WIDTH);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        RD_ADDR      = 3'd1,
        RD_DATA      = 3'd2,
        WR_ADDR_DATA = 3'd3,
        WR_RESP      = 3'd4
    } state_t;

    state_t state;

    // Only INCR bursts of full-width beats are ever issued.
    assign m_axi_awsize  = 3'(SIZE);
    assign m_axi_arsize  = 3'(SIZE);
    assign m_axi_awburst = 2'b01;
    assign m_axi_arburst = 2'b01;
    assign dbg_state     = state;

    // Transaction sequencer: the request is captured straight into the AXI payload
    // registers on accept, so the upstream inputs are free once o_rdy falls.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            o_rdy         <= 1'b1;
            o_valid       <= 1'b0;
            o_data        <= '0;
            o_err         <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awlen   <= 8'd0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_wlast   <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= 8'd0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req) begin
                        o_rdy <= 1'b0;
                        if (i_wen) begin
                            m_axi_awaddr  <= i_addr;
                            m_axi_awlen   <= 8'd0;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wdata   <= i_data;
                            m_axi_wstrb   <= i_ben;
                            m_axi_wlast   <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state         <= WR_ADDR_DATA;
                        end else begin
                            m_axi_araddr  <= i_addr;
                            // a length of 0 is treated as a single beat
                            m_axi_arlen   <= (i_len == 8'd0) ? 8'd0 : i_len - 8'd1;
                            m_axi_arvalid <= 1'b1;
                            state         <= RD_ADDR;
                        end
                    end
                end
                RD_ADDR: begin
                    if (m_axi_arvalid && m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_axi_rvalid && m_axi_rready) begin
                        o_valid <= 1'b1;
                        o_data  <= m_axi_rdata;
                        if (m_axi_rresp != 2'b00) begin
                            o_err <= 1'b1;
                        end
                        // rlast alone ends the burst; beats are not counted
                        if (m_axi_rlast) begin
                            m_axi_rready <= 1'b0;
                            o_rdy        <= 1'b1;
                            state        <= IDLE;
                        end
                    end
                end
                WR_ADDR_DATA: begin
                    if (m_axi_awvalid && m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                    end
                    if (m_axi_wvalid && m_axi_wready) begin
                        m_axi_wvalid <= 1'b0;
                        m_axi_wlast  <= 1'b0;
                    end
                    // each channel is done if it already finished or finishes now
                    if ((!m_axi_awvalid || m_axi_awready) &&
                        (!m_axi_wvalid || m_axi_wready)) begin
                        m_axi_bready <= 1'b1;
                        state        <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_axi_bvalid && m_axi_bready) begin
                        if (m_axi_bresp != 2'b00) begin
                            o_err <= 1'b1;
                        end
                        m_axi_bready <= 1'b0;
                        o_rdy        <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    o_rdy <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_axi_bridge.sv
// Bench for mem_axi_bridge: a randomized AXI slave backed by a word memory, a
// request driver, and a scoreboard that predicts read beats from the memory image.
module tb_mem_axi_bridge;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ports ----------------
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_wen = 1'b0;
    logic [BW-1:0] i_ben = '0;
    logic [7:0]    i_len = '0;
    logic [DW-1:0] i_data = '0;
    logic          o_rdy, o_valid, o_err;
    logic [DW-1:0] o_data;
    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic [7:0]    m_axi_awlen, m_axi_arlen;
    logic [2:0]    m_axi_awsize, m_axi_arsize;
    logic [1:0]    m_axi_awburst, m_axi_arburst;
    logic          m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready;
    logic          m_axi_arvalid, m_axi_rready;
    logic [DW-1:0] m_axi_wdata;
    logic [BW-1:0] m_axi_wstrb;
    logic          m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
    logic [1:0]    m_axi_bresp = 2'b00;
    logic          m_axi_arready = 1'b0, m_axi_rvalid = 1'b0, m_axi_rlast = 1'b0;
    logic [1:0]    m_axi_rresp = 2'b00;
    logic [DW-1:0] m_axi_rdata = '0;
    logic [2:0]    dbg_state;

    mem_axi_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_wen(i_wen), .i_ben(i_ben), .i_len(i_len),
        .i_data(i_data), .o_rdy(o_rdy), .o_valid(o_valid), .o_data(o_data), .o_err(o_err),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .dbg_state(dbg_state)
    );

    // ---------------- slave configuration (written by the driver only) ----------------
    logic [31:0] mem [0:255];
    int stall_pct = 0;        // chance of a stall cycle on READY / VALID
    int err_pct = 0;          // chance of an error response
    int ar_fix = -1;          // fixed ARREADY delay, -1 = random
    int aw_fix = -1;
    int w_fix = -1;
    int force_err_beat = -1;  // read beat index forced to SLVERR, -1 = none

    function automatic int pick_wait(input int fix);
        if (fix >= 0) return fix;
        return ($urandom_range(0, 99) < stall_pct) ? int'($urandom_range(1, 3)) : 0;
    endfunction

    // ---------------- AXI read slave (acts on negedge) ----------------
    int ar_hs = 0, ar_stall = 0, ar_wait = 0, stab_err = 0, r_err_cnt = 0;
    int r_pend = 0, r_k = 0;
    logic [AW-1:0] r_base = '0, cap_araddr = '0, ar_prev_addr = '0;
    logic [7:0]    cap_arlen = '0, ar_prev_len = '0;
    logic          ar_pend = 1'b0, r_err_pick = 1'b0;

    always @(negedge clk) begin
        if (!reset_n) begin
            m_axi_arready <= 1'b0;
            m_axi_rvalid  <= 1'b0;
            m_axi_rlast   <= 1'b0;
            m_axi_rresp   <= 2'b00;
            r_pend        <= 0;
            ar_pend       <= 1'b0;
            ar_wait       <= 0;
        end else begin
            r_err_pick <= ($urandom_range(0, 99) < err_pct);
            // R: beats of the burst accepted on AR in an earlier cycle
            if (r_pend != 0 && $urandom_range(0, 99) >= stall_pct) begin
                m_axi_rvalid <= 1'b1;
                m_axi_rdata  <= mem[8'(r_base[AW-1:2] + 8'(r_k))];
                m_axi_rlast  <= (r_pend == 1);
                m_axi_rresp  <= ((r_k == force_err_beat) || r_err_pick) ? 2'b10 : 2'b00;
                if (m_axi_rready) begin
                    r_k    <= r_k + 1;
                    r_pend <= r_pend - 1;
                    if ((r_k == force_err_beat) || r_err_pick) r_err_cnt <= r_err_cnt + 1;
                end
            end else begin
                m_axi_rvalid <= 1'b0;
                m_axi_rlast  <= 1'b0;
                m_axi_rresp  <= 2'b00;
            end
            // AR: fields must not move while the request waits
            if (m_axi_arvalid) begin
                if (ar_pend && (m_axi_araddr != ar_prev_addr || m_axi_arlen != ar_prev_len))
                    stab_err <= stab_err + 1;
                if (ar_wait != 0) begin
                    m_axi_arready <= 1'b0;
                    ar_wait       <= ar_wait - 1;
                    ar_stall      <= ar_stall + 1;
                    ar_pend       <= 1'b1;
                    ar_prev_addr  <= m_axi_araddr;
                    ar_prev_len   <= m_axi_arlen;
                end else begin
                    m_axi_arready <= 1'b1;
                    ar_hs         <= ar_hs + 1;
                    cap_araddr    <= m_axi_araddr;
                    cap_arlen     <= m_axi_arlen;
                    r_base        <= m_axi_araddr;
                    r_pend        <= int'(m_axi_arlen) + 1;
                    r_k           <= 0;
                    ar_pend       <= 1'b0;
                end
            end else begin
                if (ar_pend) stab_err <= stab_err + 1;
                m_axi_arready <= 1'b0;
                ar_pend       <= 1'b0;
                ar_wait       <= pick_wait(ar_fix);
            end
        end
    end

    // ---------------- AXI write slave (acts on negedge) ----------------
    int aw_hs = 0, w_hs = 0, b_hs = 0, aw_stall = 0, w_stall = 0, b_err_cnt = 0;
    int aw_wait = 0, w_wait = 0, bready_early = 0;
    logic          aw_done = 1'b0, w_done = 1'b0, b_err_pick = 1'b0;
    logic [AW-1:0] cap_awaddr = '0;
    logic [7:0]    cap_awlen = '0;
    logic [DW-1:0] cap_wdata = '0;
    logic [BW-1:0] cap_wstrb = '0;
    logic          cap_wlast = 1'b0;

    always @(negedge clk) begin
        if (!reset_n) begin
            m_axi_awready <= 1'b0;
            m_axi_wready  <= 1'b0;
            m_axi_bvalid  <= 1'b0;
            m_axi_bresp   <= 2'b00;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            aw_wait       <= 0;
            w_wait        <= 0;
        end else begin
            b_err_pick <= ($urandom_range(0, 99) < err_pct);
            if (m_axi_bready && !(aw_done && w_done)) bready_early <= bready_early + 1;
            // B: only after both AW and W have transferred
            if (aw_done && w_done && $urandom_range(0, 99) >= stall_pct) begin
                m_axi_bvalid <= 1'b1;
                m_axi_bresp  <= b_err_pick ? 2'b10 : 2'b00;
                if (m_axi_bready) begin
                    b_hs    <= b_hs + 1;
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    if (b_err_pick) b_err_cnt <= b_err_cnt + 1;
                end
            end else begin
                m_axi_bvalid <= 1'b0;
                m_axi_bresp  <= 2'b00;
            end
            if (m_axi_awvalid) begin
                if (aw_wait != 0) begin
                    m_axi_awready <= 1'b0;
                    aw_wait       <= aw_wait - 1;
                    aw_stall      <= aw_stall + 1;
                end else begin
                    m_axi_awready <= 1'b1;
                    aw_hs         <= aw_hs + 1;
                    cap_awaddr    <= m_axi_awaddr;
                    cap_awlen     <= m_axi_awlen;
                    aw_done       <= 1'b1;
                end
            end else begin
                m_axi_awready <= 1'b0;
                aw_wait       <= pick_wait(aw_fix);
            end
            if (m_axi_wvalid) begin
                if (w_wait != 0) begin
                    m_axi_wready <= 1'b0;
                    w_wait       <= w_wait - 1;
                    w_stall      <= w_stall + 1;
                end else begin
                    m_axi_wready <= 1'b1;
                    w_hs         <= w_hs + 1;
                    cap_wdata    <= m_axi_wdata;
                    cap_wstrb    <= m_axi_wstrb;
                    cap_wlast    <= m_axi_wlast;
                    w_done       <= 1'b1;
                end
            end else begin
                m_axi_wready <= 1'b0;
                w_wait       <= pick_wait(w_fix);
            end
        end
    end

    // ---------------- upstream beat monitor ----------------
    logic [DW-1:0] obs_data [0:4095];
    int            obs_cyc  [0:4095];
    logic          obs_rdy  [0:4095];
    int            obs_cnt = 0;

    always @(negedge clk) begin
        if (o_valid && obs_cnt < 4096) begin
            obs_data[obs_cnt] <= o_data;
            obs_cyc[obs_cnt]  <= cyc;
            obs_rdy[obs_cnt]  <= o_rdy;
            obs_cnt           <= obs_cnt + 1;
        end
    end

    // ---------------- scoreboard ----------------
    int n_total = 0;
    int n_bad = 0;
    logic [DW-1:0] exp_q[$];
    int exp_ar_cnt = 0, exp_aw_cnt = 0, err_base = 0;
    int acc_cyc = 0, done_cyc = 0, obs_base = 0;
    logic          cur_wen = 1'b0;
    logic [AW-1:0] cur_addr = '0;
    logic [7:0]    cur_len = '0;
    logic [BW-1:0] cur_ben = '0;
    logic [DW-1:0] cur_data = '0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_err();
        return (r_err_cnt + b_err_cnt) != err_base;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic start_req(input logic wen, input logic [AW-1:0] addr, input logic [7:0] len,
                             input logic [BW-1:0] ben, input logic [DW-1:0] data);
        int n;
        @(negedge clk); #1;
        cur_wen = wen; cur_addr = addr; cur_len = len; cur_ben = ben; cur_data = data;
        obs_base = obs_cnt;
        if (wen) begin
            exp_aw_cnt++;
        end else begin
            exp_ar_cnt++;
            n = (len == 8'd0) ? 1 : int'(len);
            for (int k = 0; k < n; k++) exp_q.push_back(mem[8'(addr[AW-1:2] + 8'(k))]);
        end
        i_req = 1'b1; i_wen = wen; i_addr = addr; i_len = len; i_ben = ben; i_data = data;
        @(negedge clk); #1;
        acc_cyc = cyc;
        // scramble the inputs: the bridge must work from its own copy
        i_req = 1'b0; i_addr = AW'($urandom); i_len = 8'($urandom);
        i_ben = BW'($urandom); i_data = $urandom; i_wen = 1'($urandom);
        check_val("ack_rdy_low", o_rdy, 1'b0);
    endtask

    task automatic finish_req(input bit busy_pulse);
        int w;
        bit done;
        logic [DW-1:0] e;
        int nb;
        w = 0; done = 0;
        while (!done && w < 300) begin
            i_req = 1'b0;
            if (o_rdy) begin
                done = 1;
            end else begin
                if (busy_pulse && w == 1) begin
                    i_req = 1'b1; i_wen = 1'($urandom); i_addr = AW'($urandom);
                    i_len = 8'($urandom_range(1, 4));
                end
                @(negedge clk); #1;
                w++;
            end
        end
        i_req = 1'b0;
        done_cyc = cyc;
        check_val("done_timeout", done, 1'b1);
        check_val("ar_count", ar_hs, exp_ar_cnt);
        check_val("aw_count", aw_hs, exp_aw_cnt);
        if (cur_wen) begin
            check_val("w_count", w_hs, exp_aw_cnt);
            check_val("b_count", b_hs, exp_aw_cnt);
            check_val("awaddr", cap_awaddr, cur_addr);
            check_val("awlen", cap_awlen, 8'd0);
            check_val("wdata", cap_wdata, cur_data);
            check_val("wstrb", cap_wstrb, cur_ben);
            check_val("wlast", cap_wlast, 1'b1);
            check_val("bready_order", bready_early, 0);
        end else begin
            nb = obs_cnt - obs_base;
            check_val("araddr", cap_araddr, cur_addr);
            check_val("arlen", cap_arlen, (cur_len == 8'd0) ? 8'd0 : cur_len - 8'd1);
            check_val("ar_stable", stab_err, 0);
            check_val("rd_beats", nb, exp_q.size());
            for (int k = 0; exp_q.size() > 0; k++) begin
                e = exp_q.pop_front();
                if (k < nb) check_val("rd_data", obs_data[obs_base + k], e);
            end
        end
        check_val("err_flag", o_err, exp_err());
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int w;
        logic          wen;
        logic [AW-1:0] addr;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        for (int i = 0; i < 4; i++) mem[16 + i] = 32'hA0 + 32'(i);

        // reset state
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_rdy", o_rdy, 1'b1);
        check_val("rst_valid", o_valid, 1'b0);
        check_val("rst_data", o_data, '0);
        check_val("rst_err", o_err, 1'b0);
        check_val("rst_state", dbg_state, 3'd0);
        check_val("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 3'b000);
        check_val("rst_readys", {m_axi_bready, m_axi_rready, m_axi_wlast}, 3'b000);
        check_val("rst_addrs", {m_axi_awaddr, m_axi_araddr}, '0);
        check_val("rst_wpayload", {m_axi_wdata, m_axi_wstrb}, '0);
        check_val("rst_lens", {m_axi_awlen, m_axi_arlen}, '0);
        check_val("axsize", {m_axi_awsize, m_axi_arsize}, {3'd2, 3'd2});
        check_val("axburst", {m_axi_awburst, m_axi_arburst}, {2'b01, 2'b01});
        reset_n = 1'b1;

        // 4-beat fill from 0x040, zero-wait slave
        start_req(1'b0, 10'h040, 8'd4, '0, '0);
        finish_req(0);
        check_val("rd_first_lat", obs_cyc[obs_base] - acc_cyc, 2);
        check_val("rd_last_data", obs_data[obs_base + 3], 32'hA3);
        check_val("rdy_with_last", obs_rdy[obs_base + 3], 1'b1);
        @(negedge clk); #1;
        check_val("rd_after_valid", o_valid, 1'b0);
        check_val("rd_after_rdy", o_rdy, 1'b1);

        // single write, zero-wait
        start_req(1'b1, 10'h104, 8'd0, 4'b0011, 32'hDEADBEEF);
        finish_req(0);
        check_val("wr_lat", done_cyc - acc_cyc, 2);

        // AW stalled 3 cycles, W immediate
        aw_fix = 3; w_fix = 0;
        begin
            int aw0, w0;
            aw0 = aw_stall; w0 = w_stall;
            start_req(1'b1, 10'h208, 8'd0, 4'b1100, 32'h12345678);
            finish_req(0);
            check_val("aw_stall", aw_stall - aw0, 3);
            check_val("w_stall", w_stall - w0, 0);
        end
        aw_fix = -1; w_fix = -1;

        // length 0 behaves as one beat
        start_req(1'b0, 10'h080, 8'd0, '0, '0);
        finish_req(0);

        // AR stalled 5 cycles, stray i_req while busy
        ar_fix = 5;
        begin
            int ar0;
            ar0 = ar_stall;
            start_req(1'b0, 10'h0C0, 8'd2, '0, '0);
            finish_req(1);
            check_val("ar_stall", ar_stall - ar0, 5);
        end
        ar_fix = -1;
        start_req(1'b1, 10'h010, 8'd0, 4'b1111, 32'hCAFEF00D);
        finish_req(1);

        // SLVERR on the second beat, then sticky across a clean read
        force_err_beat = 1;
        start_req(1'b0, 10'h100, 8'd4, '0, '0);
        finish_req(0);
        force_err_beat = -1;
        start_req(1'b0, 10'h140, 8'd2, '0, '0);
        finish_req(0);
        check_val("err_sticky", o_err, 1'b1);

        // reset in the middle of a long burst
        start_req(1'b0, 10'h200, 8'd16, '0, '0);
        w = 0;
        while (obs_cnt - obs_base < 2 && w < 100) begin
            @(negedge clk); #1;
            w++;
        end
        check_val("mid_rd_timeout", (obs_cnt - obs_base) >= 2, 1'b1);
        reset_n = 1'b0;
        @(negedge clk); #1;
        check_val("midrst_rdy", o_rdy, 1'b1);
        check_val("midrst_rready", m_axi_rready, 1'b0);
        check_val("midrst_valid", o_valid, 1'b0);
        check_val("midrst_err", o_err, 1'b0);
        check_val("midrst_arvalid", m_axi_arvalid, 1'b0);
        reset_n = 1'b1;
        exp_q.delete();
        err_base = r_err_cnt + b_err_cnt;
        start_req(1'b0, 10'h300, 8'd3, '0, '0);
        finish_req(0);

        // randomized traffic with stalls and occasional error responses
        stall_pct = 30; err_pct = 5;
        for (int t = 0; t < 40; t++) begin
            wen  = 1'($urandom);
            addr = {8'($urandom), 2'b00};
            start_req(wen, addr, 8'($urandom_range(0, 9)), BW'($urandom), $urandom);
            finish_req($urandom_range(0, 3) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
